divider_4bit_seq: RTL and testbench

//   Sequential restoring divider: unsigned WIDTH-bit dividend / divisor -> quotient, remainder.
//   One subtract-and-restore step per clock, driven through a single subtractor_4bit instance
//   (A = trial partial remainder, B = divisor, Bin = 0; Difference and Bout read back each cycle).

---
 rtl/divider_4bit_seq.sv | 143 ++++++++++++++
 tb/tb_divider_4bit_seq.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/divider_4bit_seq.sv
// divider_4bit_seq / subtractor_4bit
//
// Sequential restoring divider for unsigned 4-bit operands. The divider runs
// one subtract-and-restore step per clock through a single subtractor_4bit.
//
// divider_4bit_seq ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        request; sampled only in IDLE or DONE
//   dividend     unsigned dividend, captured when start is accepted
//   divisor      unsigned divisor, captured when start is accepted
//   busy         high while iterating
//   done         one-cycle pulse: results valid
//   quotient     result, held until the next completed operation
//   remainder    result, held until the next completed operation
//   div_by_zero  set with done when the captured divisor was zero
//
// subtractor_4bit ports:
//   A, B, Bin    minuend, subtrahend, borrow in
//   Difference   A - B - Bin (mod 16)
//   Bout         borrow out (A < B + Bin)

module subtractor_4bit (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       Bin,
  output logic [3:0] Difference,
  output logic       Bout
);

  always_comb begin
    {Bout, Difference} = {1'b0, A} - {1'b0, B} - {4'b0000, Bin};
  end

endmodule

module divider_4bit_seq #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] r, q, dvsr_reg;

  logic [WIDTH-1:0] s, diff, r_nxt, q_nxt;
  logic             bout, ovf, take, last, accept;

  subtractor_4bit u_sub (
    .A          (s),
    .B          (dvsr_reg),
    .Bin        (1'b0),
    .Difference (diff),
    .Bout       (bout)
  );

  // Shift the next dividend bit into the partial remainder. The bit shifted
  // out of R (ovf) means the true trial value is >= 2^WIDTH > divisor, so the
  // subtraction always succeeds and the modulo difference is exact.
  always_comb begin
    s     = {r[WIDTH-2:0], q[WIDTH-1]};
    ovf   = r[WIDTH-1];
    take  = ovf | ~bout;
    r_nxt = take ? diff : s;
    q_nxt = {q[WIDTH-2:0], take};
  end

  assign last   = (cnt == CNT_W'(WIDTH - 1));
  assign accept = start && ((state == IDLE) || (state == DONE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = (divisor == '0) ? DONE : RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) state_nxt = (divisor == '0) ? DONE : RUN;
        else       state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      r           <= '0;
      q           <= '0;
      dvsr_reg    <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      cnt      <= '0;
      r        <= '0;
      q        <= dividend;
      dvsr_reg <= divisor;
      // Divide-by-zero skips RUN, so results load on the accepting edge.
      if (divisor == '0) begin
        quotient    <= '1;
        remainder   <= dividend;
        div_by_zero <= 1'b1;
      end
    end else if (state == RUN) begin
      r   <= r_nxt;
      q   <= q_nxt;
      cnt <= cnt + CNT_W'(1);
      if (last) begin
        quotient    <= q_nxt;
        remainder   <= r_nxt;
        div_by_zero <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_divider_4bit_seq.sv
// tb_divider_4bit_seq
//
// Scoreboard bench for divider_4bit_seq: stimulus pushes the expected result
// into a queue when it issues an operation; a monitor pops and compares on
// every done pulse.

module tb_divider_4bit_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [3:0] dividend, divisor;
  logic       busy, done, div_by_zero;
  logic [3:0] quotient, remainder;

  typedef struct packed {
    logic [3:0] q;
    logic [3:0] r;
    logic       dz;
  } exp_t;

  exp_t        expq[$];
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  divider_4bit_seq #(.WIDTH(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: compares every done pulse against the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1 && done === 1'b1) begin
      if (expq.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        e = expq.pop_front();
        check("quotient",    int'(quotient),    int'(e.q));
        check("remainder",   int'(remainder),   int'(e.r));
        check("div_by_zero", int'(div_by_zero), int'(e.dz));
      end
    end
  end

  // Returns just after the negedge on which done is seen, or flags a timeout.
  task automatic wait_done(input string name);
    bit found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (done === 1'b1) found = 1'b1;
    end
    if (!found) check(name, 0, 1);
  endtask

  // Called just after a posedge; the DUT is in IDLE.
  task automatic run_op(input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] eq, input logic [3:0] er,
                        input logic edz, input string name);
    exp_t e;
    e.q = eq; e.r = er; e.dz = edz;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    expq.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(name);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    exp_t e;
    int   busy_cnt;
    bit   found;

    rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy",      int'(busy),        0);
    check("rst_done",      int'(done),        0);
    check("rst_quotient",  int'(quotient),    0);
    check("rst_remainder", int'(remainder),   0);
    check("rst_dbz",       int'(div_by_zero), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 13 / 3 with latency measurement
    dividend = 4'd13; divisor = 4'd3; start = 1'b1;
    e.q = 4'd4; e.r = 4'd1; e.dz = 1'b0;
    expq.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
    busy_cnt = 0; found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (done === 1'b1) found = 1'b1;
      else if (busy === 1'b1) busy_cnt++;
    end
    check("t1_done_seen",    int'(found), 1);
    check("t1_busy_cycles",  busy_cnt,    4);
    check("t1_busy_at_done", int'(busy),  0);
    @(negedge clk);
    check("t1_done_one_cycle", int'(done), 0);
    @(posedge clk); #1;

    run_op(4'd15, 4'd1, 4'd15, 4'd0, 1'b0, "t2a_timeout");
    run_op(4'd2,  4'd9, 4'd0,  4'd2, 1'b0, "t2b_timeout");

    // 7 / 0: done right after the accepting edge, never busy
    dividend = 4'd7; divisor = 4'd0; start = 1'b1;
    e.q = 4'd15; e.r = 4'd7; e.dz = 1'b1;
    expq.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
    check("t3_busy_after_accept", int'(busy), 0);
    @(negedge clk);
    check("t3_done", int'(done), 1);
    check("t3_busy", int'(busy), 0);
    @(posedge clk); #1;
    check("t3_done_cleared", int'(done), 0);
    check("t3_dbz_held",     int'(div_by_zero), 1);

    // 12 / 5 with an ignored start and changed operands mid-RUN
    dividend = 4'd12; divisor = 4'd5; start = 1'b1;
    e.q = 4'd2; e.r = 4'd2; e.dz = 1'b0;
    expq.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    dividend = 4'd3; divisor = 4'd1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("t4_timeout");
    @(posedge clk); #1;
    check("t4_quotient_held", int'(quotient), 2);

    // 14 / 3 aborted by reset on the second RUN cycle
    dividend = 4'd14; divisor = 4'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("t5_busy",      int'(busy),        0);
    check("t5_done",      int'(done),        0);
    check("t5_quotient",  int'(quotient),    0);
    check("t5_remainder", int'(remainder),   0);
    check("t5_dbz",       int'(div_by_zero), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) found = 1'b1;
    end
    check("t5_idle_after_reset", int'(found), 0);
    @(posedge clk); #1;
    run_op(4'd14, 4'd3, 4'd4, 4'd2, 1'b0, "t5b_timeout");

    // Exhaustive, back-to-back with start held high
    start = 1'b1;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        dividend = 4'(a);
        divisor  = 4'(b);
        if (b == 0) begin
          e.q = 4'd15; e.r = 4'(a); e.dz = 1'b1;
        end else begin
          e.q = 4'(a / b); e.r = 4'(a % b); e.dz = 1'b0;
        end
        expq.push_back(e);
        @(posedge clk);
        wait_done("t6_timeout");
      end
    end
    start = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);

    check("queue_drained", expq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
